// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: majority-voting UART receiver with parity/framing checks and a valid/ready RX FIFO
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int BAUD_RATE  = 57600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        FPGA_RX,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int BIT_CNT = CLK_FREQ / BAUD_RATE;
    localparam int HALF = BIT_CNT / 2;
    localparam int CW = $clog2(BIT_CNT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;
    localparam logic [CW-1:0] S0 = CW'(HALF - 1);
    localparam logic [CW-1:0] S1 = CW'(HALF);
    localparam logic [CW-1:0] S2 = CW'(HALF + 1);
    localparam logic [CW-1:0] WRAP = CW'(BIT_CNT - 1);
    localparam logic [BW-1:0] LAST_D = BW'(DATA_BITS - 1);
    localparam logic LAST_S = (STOP_BITS == 2);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PAR = 3'd3, STOP = 3'd4;

    logic [1:0]           sync_q;
    logic                 rx_sync, v0, v1, maj, mid, wrap, ferr_n;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bidx;
    logic                 sidx, perr, ferr, hold, push;
    logic [DATA_BITS-1:0] shreg;
    logic [EW-1:0]        push_word;
    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wr, rd;
    logic                 full, pop, wen;

    assign rx_sync = sync_q[1];
    assign maj = (v0 & v1) | (v0 & rx_sync) | (v1 & rx_sync);
    assign mid = cnt == S2;
    assign wrap = cnt == WRAP;
    assign ferr_n = ferr | ~maj;

    // Synchroniser, bit timing and frame FSM; the finished frame is registered into push_word
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state     <= IDLE;
            cnt       <= '0;
            bidx      <= '0;
            sidx      <= 1'b0;
            v0        <= 1'b1;
            v1        <= 1'b1;
            shreg     <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            hold      <= 1'b0;
            push      <= 1'b0;
            push_word <= '0;
        end else begin
            sync_q <= {sync_q[0], FPGA_RX};
            push   <= 1'b0;
            if (cnt == S0) v0 <= rx_sync;
            if (cnt == S1) v1 <= rx_sync;
            cnt <= (state == IDLE || wrap) ? '0 : cnt + CW'(1);
            case (state)
                IDLE: begin
                    if (hold && rx_sync) hold <= 1'b0;
                    if (!hold && !rx_sync) begin
                        state <= START;
                        cnt   <= CW'(1);
                        bidx  <= '0;
                        sidx  <= 1'b0;
                        perr  <= 1'b0;
                        ferr  <= 1'b0;
                    end
                end
                START: begin
                    if (mid && maj) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (wrap) state <= DATA;
                end
                DATA: begin
                    if (mid) shreg <= {maj, shreg[DATA_BITS-1:1]};
                    if (wrap) begin
                        bidx <= bidx + BW'(1);
                        if (bidx == LAST_D) state <= (PARITY != 0) ? PAR : STOP;
                    end
                end
                PAR: begin
                    if (mid) perr <= (^{shreg, maj}) != (PARITY == 1);
                    if (wrap) state <= STOP;
                end
                STOP: begin
                    if (mid) ferr <= ferr_n;
                    if (mid && sidx == LAST_S) begin
                        push      <= 1'b1;
                        push_word <= {ferr_n, perr, shreg};
                        hold      <= ferr_n;
                        state     <= IDLE;
                        cnt       <= '0;
                    end else if (wrap) sidx <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign full = fifo_count == FULL;
    assign rx_valid = fifo_count != '0;
    assign pop = rx_valid & rx_ready;
    assign wen = push & (~full | pop);
    assign {frame_err, parity_err, rx_data} = rx_valid ? mem[rd] : '0;

    // FIFO pointers, occupancy and overrun pulse when a frame arrives with no room
    always_ff @(posedge clk) begin
        if (rst) begin
            wr         <= '0;
            rd         <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            overrun    <= push & full & ~pop;
            wr         <= wen ? wr + AW'(1) : wr;
            rd         <= pop ? rd + AW'(1) : rd;
            fifo_count <= fifo_count + {{AW{1'b0}}, wen} - {{AW{1'b0}}, pop};
        end
    end

    // FIFO storage; contents are only observable through the head while non-empty
    always_ff @(posedge clk) begin
        if (wen) mem[wr] <= push_word;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table vectors, corner sequences and a randomized scoreboard for uart_rx_fifo
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] rx = '1;
    logic [3:0] rdy = '0;
    logic [7:0] d0, d1, d3;
    logic [6:0] d2;
    logic [3:0] pe, fe, vl, ov;
    logic [3:0][2:0] cn;
    int ovc [4] = '{0, 0, 0, 0};
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_rx_fifo u0 (.clk(clk), .rst(rst), .FPGA_RX(rx[0]), .rx_data(d0), .parity_err(pe[0]), .frame_err(fe[0]),
                     .rx_valid(vl[0]), .rx_ready(rdy[0]), .overrun(ov[0]), .fifo_count(cn[0]));
    uart_rx_fifo #(.PARITY(2)) u1 (.clk(clk), .rst(rst), .FPGA_RX(rx[1]), .rx_data(d1), .parity_err(pe[1]),
                     .frame_err(fe[1]), .rx_valid(vl[1]), .rx_ready(rdy[1]), .overrun(ov[1]), .fifo_count(cn[1]));
    uart_rx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (.clk(clk), .rst(rst), .FPGA_RX(rx[2]), .rx_data(d2),
                     .parity_err(pe[2]), .frame_err(fe[2]), .rx_valid(vl[2]), .rx_ready(rdy[2]), .overrun(ov[2]),
                     .fifo_count(cn[2]));
    uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .PARITY(2)) u3 (.clk(clk), .rst(rst), .FPGA_RX(rx[3]),
                     .rx_data(d3), .parity_err(pe[3]), .frame_err(fe[3]), .rx_valid(vl[3]), .rx_ready(rdy[3]),
                     .overrun(ov[3]), .fifo_count(cn[3]));

    // Count overrun cycles per instance
    always @(negedge clk) for (int i = 0; i < 4; i++) if (ov[i]) ovc[i]++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic int bc_of(input int ch);
        return ch == 3 ? 16 : 208;
    endfunction

    function automatic int db_of(input int ch);
        return ch == 2 ? 7 : 8;
    endfunction

    function automatic int par_of(input int ch);
        return ch == 0 ? 0 : (ch == 2 ? 1 : 2);
    endfunction

    function automatic logic [8:0] data_of(input int ch);
        return ch == 0 ? {1'b0, d0} : ch == 1 ? {1'b0, d1} : ch == 2 ? {2'b00, d2} : {1'b0, d3};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pop(input int ch);
        rdy[ch] = 1'b1;
        cyc(1);
        rdy[ch] = 1'b0;
    endtask

    // Builds a frame from the line rules and drives it; gb selects a bit that gets a 1-cycle inversion mid-bit
    task automatic send(input int ch, input logic [8:0] data, input logic pbad, input logic [1:0] s0, input int gb);
        logic bits[$];
        int bc;
        int db;
        logic [8:0] dm;
        bc = bc_of(ch);
        db = db_of(ch);
        dm = data & ((9'h1 << db) - 9'h1);
        bits.push_back(1'b0);
        for (int i = 0; i < db; i++) bits.push_back(dm[i]);
        if (par_of(ch) != 0) bits.push_back((^dm) ^ (par_of(ch) == 1) ^ pbad);
        for (int i = 0; i < (ch == 2 ? 2 : 1); i++) bits.push_back(~s0[i]);
        for (int j = 0; j < bits.size(); j++) begin
            rx[ch] = bits[j];
            if (j == gb) begin
                cyc(bc / 2);
                rx[ch] = ~bits[j];
                cyc(1);
                rx[ch] = bits[j];
                cyc(bc - bc / 2 - 1);
            end else cyc(bc);
        end
        rx[ch] = 1'b1;
    endtask

    typedef struct {
        int         ch;
        logic [8:0] data;
        logic       pbad;
        logic [1:0] s0;
        int         gb;
        logic [8:0] ed;
        logic       ep;
        logic       ef;
    } vec_t;

    vec_t tv [11];
    logic [9:0] expq[$];
    logic done = 1'b0;
    int ob;
    localparam int K = 9 * 208 + 208 / 2 + 4;

    initial begin
        tv[0]  = '{0, 9'hA5, 1'b0, 2'b00, -1, 9'hA5, 1'b0, 1'b0};
        tv[1]  = '{1, 9'h03, 1'b1, 2'b00, -1, 9'h03, 1'b1, 1'b0};
        tv[2]  = '{1, 9'h03, 1'b0, 2'b00, -1, 9'h03, 1'b0, 1'b0};
        tv[3]  = '{0, 9'h55, 1'b0, 2'b01, -1, 9'h55, 1'b0, 1'b1};
        tv[4]  = '{0, 9'h55, 1'b0, 2'b00, 3, 9'h55, 1'b0, 1'b0};
        tv[5]  = '{0, 9'hC3, 1'b0, 2'b00, 0, 9'hC3, 1'b0, 1'b0};
        tv[6]  = '{2, 9'h7F, 1'b0, 2'b00, -1, 9'h7F, 1'b0, 1'b0};
        tv[7]  = '{2, 9'h15, 1'b0, 2'b10, -1, 9'h15, 1'b0, 1'b1};
        tv[8]  = '{1, 9'hFF, 1'b0, 2'b00, -1, 9'hFF, 1'b0, 1'b0};
        tv[9]  = '{0, 9'h3C, 1'b0, 2'b00, 9, 9'h3C, 1'b0, 1'b0};
        tv[10] = '{2, 9'h7F, 1'b1, 2'b00, -1, 9'h7F, 1'b1, 1'b0};

        cyc(5);
        chk("reset_valid", vl[0], 0);
        chk("reset_count", cn[0], 0);
        chk("reset_data", d0, 0);
        chk("reset_perr", pe[0], 0);
        chk("reset_ferr", fe[0], 0);
        chk("reset_overrun", ov[0], 0);
        rst = 1'b0;
        cyc(5);

        rdy[0] = 1'b1;
        cyc(3);
        rdy[0] = 1'b0;
        chk("ready_empty_count", cn[0], 0);

        rx[0] = 1'b0;
        cyc(1);
        rx[0] = 1'b1;
        cyc(2 * 208);
        chk("idle_glitch_valid", vl[0], 0);
        chk("idle_glitch_count", cn[0], 0);

        for (int i = 0; i < 11; i++) begin
            send(tv[i].ch, tv[i].data, tv[i].pbad, tv[i].s0, tv[i].gb);
            cyc(20);
            chk($sformatf("vec%0d_valid", i), vl[tv[i].ch], 1);
            chk($sformatf("vec%0d_data", i), data_of(tv[i].ch), tv[i].ed);
            chk($sformatf("vec%0d_perr", i), pe[tv[i].ch], tv[i].ep);
            chk($sformatf("vec%0d_ferr", i), fe[tv[i].ch], tv[i].ef);
            chk($sformatf("vec%0d_count", i), cn[tv[i].ch], 1);
            pop(tv[i].ch);
            chk($sformatf("vec%0d_popped_valid", i), vl[tv[i].ch], 0);
            chk($sformatf("vec%0d_popped_count", i), cn[tv[i].ch], 0);
        end

        ob = ovc[0];
        for (int i = 1; i <= 5; i++) send(0, 9'(i), 1'b0, 2'b00, -1);
        cyc(20);
        chk("full_count", cn[0], 4);
        chk("full_overrun_pulses", ovc[0] - ob, 1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("full_pop%0d", i), d0, i);
            pop(0);
        end
        chk("full_drained", cn[0], 0);

        for (int i = 'h11; i <= 'h14; i++) send(0, 9'(i), 1'b0, 2'b00, -1);
        cyc(20);
        chk("pp_prefill", cn[0], 4);
        ob = ovc[0];
        fork
            send(0, 9'h15, 1'b0, 2'b00, -1);
            begin
                cyc(K);
                chk("pp_count_before", cn[0], 4);
                rdy[0] = 1'b1;
                cyc(1);
                rdy[0] = 1'b0;
                chk("pp_count_after", cn[0], 4);
            end
        join
        cyc(20);
        chk("pp_no_overrun", ovc[0] - ob, 0);
        for (int i = 'h12; i <= 'h15; i++) begin
            chk($sformatf("pp_pop%0h", i), d0, i);
            pop(0);
        end
        chk("pp_drained", cn[0], 0);

        rx[0] = 1'b0;
        cyc(12 * 208);
        rx[0] = 1'b1;
        cyc(20);
        chk("break_count", cn[0], 1);
        chk("break_data", d0, 0);
        chk("break_ferr", fe[0], 1);
        pop(0);

        fork
            send(2, 9'h7E, 1'b0, 2'b00, -1);
            begin
                cyc(3 * 208 + 104);
                rst = 1'b1;
                cyc(1);
                rst = 1'b0;
            end
        join
        cyc(20);
        chk("rst_mid_valid", vl[2], 0);
        chk("rst_mid_count", cn[2], 0);
        send(2, 9'h2A, 1'b0, 2'b00, -1);
        cyc(20);
        chk("post_rst_valid", vl[2], 1);
        chk("post_rst_data", d2, 7'h2A);
        chk("post_rst_err", {pe[2], fe[2]}, 0);
        pop(2);

        ob = ovc[3];
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    logic [7:0] dat;
                    logic pb, se;
                    dat = 8'($urandom_range(0, 255));
                    pb = $urandom_range(0, 4) == 0;
                    se = $urandom_range(0, 5) == 0;
                    expq.push_back({se, pb, dat});
                    send(3, {1'b0, dat}, pb, {1'b0, se}, -1);
                    cyc(se ? 2 + $urandom_range(0, 20) : $urandom_range(0, 20));
                end
                cyc(100);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    logic r;
                    @(negedge clk);
                    r = 1'($urandom_range(0, 1));
                    if (vl[3] && r) begin
                        chk("rand_model_has_entry", expq.size() != 0, 1);
                        if (expq.size() != 0) chk("rand_entry", {fe[3], pe[3], d3}, expq.pop_front());
                    end
                    rdy[3] = r;
                end
                rdy[3] = 1'b0;
            end
        join
        chk("rand_model_left", expq.size(), 0);
        chk("rand_fifo_empty", cn[3], 0);
        chk("rand_overrun", ovc[3] - ob, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
